pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Central stall/flush sequencer for the five-stage pipelined RISC-V core. It drives write-enable and flush (bubble-insert) controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazard sources: load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses using a req/ready handshake. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the unit halts.
- CNT_W, 16: performance counter width.

Ports:
- clk_i  in  1  clock. Everything is on posedge.
- rst_i  in  1  reset. Asynchronous, active-low.
- id_rs1_i, id_rs2_i  in  5 each  source register indices of the instruction in ID.
- id_use_rs1_i, id_use_rs2_i  in  1 each  the ID instruction actually reads rs1 / rs2.
- ex_memread_i  in  1  the instruction in EX is a load.
- ex_rd_i  in  5  destination register of the instruction in EX.
- ex_redirect_i  in  1  taken branch, jal or jalr resolved in EX.
- mem_req_i  in  1  the instruction in MEM has MemRead or MemWrite set.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- dmem_req_o  out  1  data memory request.
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o  out  1 each  register load enables.
- ifid_flush_o, idex_flush_o, memwb_flush_o  out  1 each  load a bubble (all zero) instead of the input.
- halted_o  out  1  the unit is in HALT.
- err_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  count of stall cycles (freeze or load-use).
- flush_cnt_o  out  CNT_W  count of redirect flushes.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- The control outputs are combinational from the state and the inputs. The counters, wait counter and err_o are registered.

RUN:
- Default: all *_we_o = 1 and all flushes = 0.
- dmem_req_o = mem_req_i.
- If mem_req_i and !dmem_ready_i: treat as a freeze (same outputs as MEM_WAIT) and go to MEM_WAIT next cycle.
- If mem_req_i and dmem_ready_i: zero-wait access. No stall; stay in RUN.
- Load-use hazard: ex_memread_i and ex_rd_i != 0 and ((id_use_rs1_i and id_rs1_i == ex_rd_i) or (id_use_rs2_i and id_rs2_i == ex_rd_i)).
  - Response: pc_we_o = 0, ifid_we_o = 0, idex_flush_o = 1.
- Redirect (ex_redirect_i): ifid_flush_o = 1, idex_flush_o = 1, pc_we_o = 1 (PC loads the target).
- Priority is freeze > redirect > load-use. A redirect cancels a simultaneous load-use stall, because the ID instruction is discarded anyway.

MEM_WAIT:
- dmem_req_o is held at 1. pc/ifid/idex/exmem we = 0 and memwb_flush_o = 1. EX inputs are frozen, so ex_redirect_i stays stable.
- On dmem_ready_i: this is the release cycle. Outputs are the same as RUN evaluated with the current inputs, but without a new freeze for the completing access. Go to RUN.
- The wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT with no ready: set err_o and go to HALT.

HALT:
- All we = 0, memwb_flush_o = 1, dmem_req_o = 0, halted_o = 1.
- The only exit is reset.

Counters:
- stall_cnt_o increments in every cycle with pc_we_o == 0.
- flush_cnt_o increments in every cycle with an applied redirect.
- Both saturate at 2^CNT_W - 1 and do not wrap.

## Timing
- Hazard responses take effect in the same cycle (zero latency). The bubble appears in the downstream register at the next edge.
- A load-use stall lasts exactly 1 cycle: on the next cycle the load is in MEM and the hazard condition is false.
- Memory handshake: the transfer occurs in the cycle where dmem_req_o and dmem_ready_i are both 1. The request must not drop before ready, except on entry to HALT.
- A ready arriving on the same cycle the wait counter hits MEM_TIMEOUT counts as success (ready wins).
- While rst_i is low: all outputs are 0, state is RUN, counters, wait counter and err_o are 0.
- Reset asserted mid-MEM_WAIT aborts the request immediately (dmem_req_o falls asynchronously).

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - the 5-bit x0 constant;
  - a load_use_hazard function shared with the forwarding unit.
- Sub-module pipe_perf_counter: saturating counter with a CNT_W parameter and an inc input. It is instantiated twice (stall and flush).

## Test plan
- Load x5, then add using x5 in ID: one cycle with pc_we = 0, ifid_we = 0, idex_flush = 1. stall_cnt goes from 0 to 1. Repeat with rd = x0: no stall.
- Redirect coinciding with a load-use hazard: ifid_flush = idex_flush = 1, pc_we = 1, flush_cnt = 1, stall_cnt unchanged.
- Store with ready asserted 3 cycles late: 3 freeze cycles with dmem_req held at 1 and memwb_flush = 1, release on the 4th cycle, stall_cnt = 3.
- Zero-wait access (ready in the same cycle): no freeze and the state stays in RUN.
- MEM_TIMEOUT = 4, ready never asserted: after 4 wait cycles, err_o = halted_o = 1 and dmem_req_o = 0. Also drive ready on exactly the 4th cycle: the unit returns to RUN and err_o stays 0.
- rst_i pulled low mid-MEM_WAIT: outputs drop asynchronously. After release the unit is in RUN with counters at 0. With CNT_W = 4 and a forced 20-cycle stall, stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types, constants and hazard helper for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pipe_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Load in EX writes a register that the ID instruction reads; x0 never hazards.
    function automatic logic load_use_hazard(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        return ex_memread && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module pipe_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Count qualifying cycles, stop at the maximum value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_cnt <= '0;
        else if (inc_i && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall/flush sequencer: load-use, EX redirect and data-memory wait handling.
//
// state       | meaning
// ST_RUN      | normal flow; hazards resolved combinationally
// ST_MEM_WAIT | data access outstanding; pipeline frozen until ready
// ST_HALT     | memory timeout; frozen until reset
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             idex_we_o,
    output logic             exmem_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             memwb_flush_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    pipe_state_t       r_state;
    pipe_state_t       w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_timeout;
    logic              r_err;
    logic              w_hazard;
    logic              w_redirect_applied;

    assign w_hazard    = load_use_hazard(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i,
                                         id_use_rs1_i, id_use_rs2_i);
    assign w_wait_next = r_wait_cnt + WAIT_W'(1);
    // Ready in the same cycle as the limit takes precedence over the timeout.
    assign w_timeout   = (r_state == ST_MEM_WAIT) && !dmem_ready_i &&
                         (w_wait_next == WAIT_W'(MEM_TIMEOUT));

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    // Wait-cycle counter and sticky timeout error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == ST_MEM_WAIT) && !dmem_ready_i)
                r_wait_cnt <= w_wait_next;
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (mem_req_i && !dmem_ready_i) w_state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (dmem_ready_i)   w_state_next = ST_RUN;
                else if (w_timeout) w_state_next = ST_HALT;
            end
            ST_HALT:     w_state_next = ST_HALT;
            default:     w_state_next = ST_RUN;
        endcase
    end

    // Control outputs; everything forced low while reset is asserted.
    always_comb begin
        dmem_req_o         = 1'b0;
        pc_we_o            = 1'b1;
        ifid_we_o          = 1'b1;
        idex_we_o          = 1'b1;
        exmem_we_o         = 1'b1;
        ifid_flush_o       = 1'b0;
        idex_flush_o       = 1'b0;
        memwb_flush_o      = 1'b0;
        halted_o           = 1'b0;
        w_redirect_applied = 1'b0;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                // The request stays up for the whole wait, including the release cycle.
                dmem_req_o = (r_state == ST_MEM_WAIT) ? 1'b1 : mem_req_i;
                if (((r_state == ST_RUN) && mem_req_i && !dmem_ready_i) ||
                    ((r_state == ST_MEM_WAIT) && !dmem_ready_i)) begin
                    pc_we_o       = 1'b0;
                    ifid_we_o     = 1'b0;
                    idex_we_o     = 1'b0;
                    exmem_we_o    = 1'b0;
                    memwb_flush_o = 1'b1;
                end else if (ex_redirect_i) begin
                    ifid_flush_o       = 1'b1;
                    idex_flush_o       = 1'b1;
                    w_redirect_applied = 1'b1;
                end else if (w_hazard) begin
                    pc_we_o      = 1'b0;
                    ifid_we_o    = 1'b0;
                    idex_flush_o = 1'b1;
                end
            end
            default: begin
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                idex_we_o     = 1'b0;
                exmem_we_o    = 1'b0;
                memwb_flush_o = 1'b1;
                halted_o      = 1'b1;
            end
        endcase
        if (!rst_i) begin
            dmem_req_o         = 1'b0;
            pc_we_o            = 1'b0;
            ifid_we_o          = 1'b0;
            idex_we_o          = 1'b0;
            exmem_we_o         = 1'b0;
            ifid_flush_o       = 1'b0;
            idex_flush_o       = 1'b0;
            memwb_flush_o      = 1'b0;
            halted_o           = 1'b0;
            w_redirect_applied = 1'b0;
        end
    end

    assign err_o = r_err;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!pc_we_o),
        .cnt_o (stall_cnt_o)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_redirect_applied),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with a short timeout and narrow counters.
module tb_pipe_ctrl_unit;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
    logic             id_use_rs1_i, id_use_rs2_i, ex_memread_i, ex_redirect_i;
    logic             mem_req_i, dmem_ready_i;
    logic             dmem_req_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o;
    logic             ifid_flush_o, idex_flush_o, memwb_flush_o, halted_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .ex_memread_i  (ex_memread_i),
        .ex_rd_i       (ex_rd_i),
        .ex_redirect_i (ex_redirect_i),
        .mem_req_i     (mem_req_i),
        .dmem_ready_i  (dmem_ready_i),
        .dmem_req_o    (dmem_req_o),
        .pc_we_o       (pc_we_o),
        .ifid_we_o     (ifid_we_o),
        .idex_we_o     (idex_we_o),
        .exmem_we_o    (exmem_we_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_flush_o  (idex_flush_o),
        .memwb_flush_o (memwb_flush_o),
        .halted_o      (halted_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr_inputs();
        id_rs1_i      = 5'd0;
        id_rs2_i      = 5'd0;
        id_use_rs1_i  = 1'b0;
        id_use_rs2_i  = 1'b0;
        ex_memread_i  = 1'b0;
        ex_rd_i       = 5'd0;
        ex_redirect_i = 1'b0;
        mem_req_i     = 1'b0;
        dmem_ready_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
    endtask

    task automatic freeze_checks(input string tag);
        chk({tag, ".req"},   32'(dmem_req_o),    32'd1);
        chk({tag, ".pc_we"}, 32'(pc_we_o),       32'd0);
        chk({tag, ".mw_fl"}, 32'(memwb_flush_o), 32'd1);
        chk({tag, ".em_we"}, 32'(exmem_we_o),    32'd0);
    endtask

    initial begin
        // Outputs gated while reset is held, even with active inputs.
        clr_inputs();
        rst_i         = 1'b0;
        mem_req_i     = 1'b1;
        ex_redirect_i = 1'b1;
        #2;
        chk("rst.req",    32'(dmem_req_o),   32'd0);
        chk("rst.pc_we",  32'(pc_we_o),      32'd0);
        chk("rst.if_fl",  32'(ifid_flush_o), 32'd0);
        chk("rst.halted", 32'(halted_o),     32'd0);
        chk("rst.err",    32'(err_o),        32'd0);
        chk("rst.stall",  32'(stall_cnt_o),  32'd0);
        do_reset();
        chk("idle.pc_we", 32'(pc_we_o), 32'd1);
        chk("idle.if_we", 32'(ifid_we_o), 32'd1);

        // Load x5 in EX, add reading x5 in ID.
        ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
        #1;
        chk("lu.pc_we",   32'(pc_we_o),      32'd0);
        chk("lu.if_we",   32'(ifid_we_o),    32'd0);
        chk("lu.ie_fl",   32'(idex_flush_o), 32'd1);
        chk("lu.ie_we",   32'(idex_we_o),    32'd1);
        chk("lu.stall0",  32'(stall_cnt_o),  32'd0);
        tick();
        ex_memread_i = 1'b0;
        #1;
        chk("lu.pc_we_after", 32'(pc_we_o),     32'd1);
        chk("lu.stall1",      32'(stall_cnt_o), 32'd1);

        // Load into x0: no hazard.
        ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0;
        #1;
        chk("x0.pc_we", 32'(pc_we_o), 32'd1);
        tick();
        chk("x0.stall", 32'(stall_cnt_o), 32'd1);

        // rs2 match only counts when rs2 is actually used.
        ex_rd_i = 5'd7; id_rs1_i = 5'd3; id_rs2_i = 5'd7; id_use_rs2_i = 1'b0;
        #1;
        chk("rs2.unused", 32'(pc_we_o), 32'd1);
        id_use_rs2_i = 1'b1;
        #1;
        chk("rs2.used", 32'(pc_we_o), 32'd0);
        tick();
        ex_memread_i = 1'b0;
        #1;
        chk("rs2.stall", 32'(stall_cnt_o), 32'd2);

        // Redirect with a simultaneous load-use hazard: redirect wins.
        ex_memread_i = 1'b1; ex_redirect_i = 1'b1;
        #1;
        chk("rd.if_fl", 32'(ifid_flush_o), 32'd1);
        chk("rd.ie_fl", 32'(idex_flush_o), 32'd1);
        chk("rd.pc_we", 32'(pc_we_o),      32'd1);
        tick();
        clr_inputs();
        #1;
        chk("rd.flush", 32'(flush_cnt_o), 32'd1);
        chk("rd.stall", 32'(stall_cnt_o), 32'd2);

        // Store whose ready arrives three cycles late.
        do_reset();
        mem_req_i = 1'b1;
        #1;
        freeze_checks("st.c0");
        tick();
        freeze_checks("st.c1");
        tick();
        freeze_checks("st.c2");
        tick();
        dmem_ready_i = 1'b1;
        #1;
        chk("st.rel.req",   32'(dmem_req_o),    32'd1);
        chk("st.rel.pc_we", 32'(pc_we_o),       32'd1);
        chk("st.rel.mw_fl", 32'(memwb_flush_o), 32'd0);
        tick();
        chk("st.stall", 32'(stall_cnt_o), 32'd3);

        // Zero-wait access: stays in RUN.
        #1;
        chk("zw.pc_we", 32'(pc_we_o),       32'd1);
        chk("zw.mw_fl", 32'(memwb_flush_o), 32'd0);
        tick();
        mem_req_i = 1'b0; dmem_ready_i = 1'b0;
        #1;
        chk("zw.run",   32'(pc_we_o),     32'd1);
        chk("zw.stall", 32'(stall_cnt_o), 32'd3);

        // Timeout with no ready: one RUN freeze then four wait cycles.
        do_reset();
        mem_req_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to.w4.halted", 32'(halted_o), 32'd0);
        chk("to.w4.req",    32'(dmem_req_o), 32'd1);
        tick();
        chk("to.halted", 32'(halted_o),      32'd1);
        chk("to.err",    32'(err_o),         32'd1);
        chk("to.req",    32'(dmem_req_o),    32'd0);
        chk("to.mw_fl",  32'(memwb_flush_o), 32'd1);
        chk("to.stall",  32'(stall_cnt_o),   32'd5);
        mem_req_i = 1'b0; dmem_ready_i = 1'b1;
        tick();
        chk("to.sticky", 32'(halted_o), 32'd1);

        // Ready on exactly the fourth wait cycle succeeds.
        do_reset();
        mem_req_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        dmem_ready_i = 1'b1;
        #1;
        chk("tr.rel.pc_we", 32'(pc_we_o), 32'd1);
        tick();
        mem_req_i = 1'b0; dmem_ready_i = 1'b0;
        #1;
        chk("tr.halted", 32'(halted_o),    32'd0);
        chk("tr.err",    32'(err_o),       32'd0);
        chk("tr.run",    32'(pc_we_o),     32'd1);
        chk("tr.stall",  32'(stall_cnt_o), 32'd4);

        // Reset mid-wait drops the request immediately.
        do_reset();
        mem_req_i = 1'b1;
        tick();
        chk("ar.req_before", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("ar.req",   32'(dmem_req_o),  32'd0);
        chk("ar.stall", 32'(stall_cnt_o), 32'd0);
        mem_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("ar.run", 32'(pc_we_o), 32'd1);
        tick();
        chk("ar.stall_after", 32'(stall_cnt_o), 32'd0);

        // Counter saturation with a held 20-cycle stall.
        ex_memread_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat.stall", 32'(stall_cnt_o), 32'd15);
        clr_inputs();
        tick();
        chk("sat.hold", 32'(stall_cnt_o), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
